// File: rtl/mult_pkg.sv
// Shared types for the Booth multiplier and its issue queue: default operand
// width, issue FSM states and the operand-pair record.
package mult_pkg;

    localparam int unsigned N_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT
    } state_t;

    typedef struct packed {
        logic [N_DEFAULT-1:0] a;
        logic [N_DEFAULT-1:0] b;
    } operand_pair_t;

endpackage

// File: rtl/operand_fifo.sv
// DEPTH x WIDTH operand FIFO with a registered head read on pop, an occupancy
// count and a registered not-full flag.
module operand_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ready
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    // ready looks at the next count so a push can never land in a full FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready    <= 1'b1;
            pop_data <= '0;
        end else begin
            count <= count_next;
            ready <= (count_next != CW'(DEPTH));
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                pop_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: rtl/booth_issue_queue.sv
// Buffers signed operand pairs, issues them one at a time to booth_multiplier
// and holds each product on a valid/ready output until consumed.
module booth_issue_queue
    import mult_pkg::*;
#(
    parameter int unsigned N       = N_DEFAULT,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N-1:0]           in_a,
    input  logic [N-1:0]           in_b,
    output logic                   mul_start,
    output logic [N-1:0]           mul_multiplicand,
    output logic [N-1:0]           mul_multiplier,
    input  logic [2*N-1:0]         mul_product,
    input  logic                   mul_done,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*N-1:0]         out_product,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic                   timeout_err
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_t         state;
    state_t         state_next;
    logic [TW-1:0]  timer;
    logic           timer_hit;
    logic           push;
    logic           pop;
    logic [2*N-1:0] head;

    assign push      = in_valid && in_ready;
    assign pop       = (state == IDLE) && (fifo_count != '0) && !out_valid;
    assign timer_hit = (timer == TW'(TIMEOUT - 1));

    // The FIFO head register doubles as the operand register: it only changes
    // on pop, so the operands stay stable until the product is captured.
    operand_fifo #(
        .WIDTH (2 * N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({in_a, in_b}),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .ready     (in_ready)
    );

    assign mul_multiplicand = head[2*N-1:N];
    assign mul_multiplier   = head[N-1:0];
    assign mul_start        = (state == ISSUE);
    assign busy             = (state != IDLE) || (fifo_count != '0);

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pop) state_next = ISSUE;
            ISSUE:   state_next = ARM;
            ARM:     state_next = WAIT;
            WAIT:    if (mul_done || timer_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // A timed-out operation still completes, with a zero product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer       <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state == ISSUE)
                timer <= '0;
            else if (state == WAIT && !mul_done)
                timer <= timer + 1'b1;

            if (state == WAIT && mul_done) begin
                out_product <= mul_product;
                out_valid   <= 1'b1;
            end else if (state == WAIT && timer_hit) begin
                out_product <= '0;
                out_valid   <= 1'b1;
                timeout_err <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
